// File: rtl/fx_acc_sat_pkg.sv
// fx_pkg: shared types and constants for the Q4.4 frame accumulator.
//   q44_t    : signed Q4.4 sample (8 bits)
//   Q44_MAX  : largest Q4.4 value (+7.9375)
//   Q44_MIN  : smallest Q4.4 value (-8.0)
//   ACC_W    : accumulator width (8 + log2 of 16 samples)
//   state_t  : accumulator FSM states
package fx_pkg;

  typedef logic signed [7:0] q44_t;

  localparam q44_t Q44_MAX = 8'h7F;
  localparam q44_t Q44_MIN = 8'h80;
  localparam int   ACC_W   = 12;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

endpackage

// File: rtl/fx_acc_sat_if.sv
// fx_acc_sat_if: sample stream in, frame-sum stream out.
//   din/in_valid/in_last/in_ready : input sample handshake
//   dout/sat/out_valid/out_ready  : result handshake
//   master : the producer/consumer side (drives samples, accepts results)
//   slave  : the accumulator side
interface fx_acc_sat_if;
  import fx_pkg::*;

  q44_t din;
  logic in_valid;
  logic in_last;
  logic in_ready;
  q44_t dout;
  logic sat;
  logic out_valid;
  logic out_ready;

  modport master (
    output din, in_valid, in_last, out_ready,
    input  in_ready, dout, sat, out_valid
  );

  modport slave (
    input  din, in_valid, in_last, out_ready,
    output in_ready, dout, sat, out_valid
  );

endinterface

// File: rtl/fx_sat.sv
// fx_sat: combinational clip of a wide signed sum to Q4.4.
//   val : ACC_W-bit signed sum
//   q   : clipped Q4.4 value
//   sat : 1 when clipping occurred
// No rounding: the fractional bits already line up with Q4.4.
module fx_sat
  import fx_pkg::*;
(
  input  logic signed [ACC_W-1:0] val,
  output q44_t                    q,
  output logic                    sat
);

  // Clip to the Q4.4 range and flag any clipping
  always_comb begin
    q   = val[7:0];
    sat = 1'b0;
    if (val > 12'sd127) begin
      q   = Q44_MAX;
      sat = 1'b1;
    end else if (val < -12'sd128) begin
      q   = Q44_MIN;
      sat = 1'b1;
    end else begin
      q   = val[7:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/fx_acc_sat.sv
// fx_acc_sat: accumulates a frame of signed Q4.4 samples in a wide register
// and emits the saturated Q4.4 frame sum.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fx_acc_sat_if.slave (sample input and result output handshakes)
// A frame closes on the accepted beat carrying in_last, or on the LEN-th
// beat, whichever comes first. The result is held until out_ready; input is
// back-pressured meanwhile, so frames never overlap.
module fx_acc_sat
  import fx_pkg::*;
#(
  parameter int LEN = 16
) (
  input logic          clk,
  input logic          rst,
  fx_acc_sat_if.slave  bus
);

  state_t                  state_r;
  state_t                  next_state_s;
  logic signed [ACC_W-1:0] acc_r;
  logic [4:0]              cnt_r;
  q44_t                    dout_r;
  logic                    sat_r;

  logic                    accept_s;
  logic                    close_s;
  logic signed [ACC_W-1:0] din_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  q44_t                    sum_q_s;
  logic                    sum_sat_s;

  assign accept_s  = bus.in_valid && (state_r == S_ACC);
  assign din_ext_s = {{(ACC_W-8){bus.din[7]}}, bus.din};
  // Full-width sum including the current beat; only this final value is clipped
  assign sum_s     = acc_r + din_ext_s;
  assign close_s   = accept_s && (bus.in_last || (cnt_r == 5'(LEN - 1)));

  fx_sat u_sat (
    .val (sum_s),
    .q   (sum_q_s),
    .sat (sum_sat_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_ACC;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    next_state_s  = state_r;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_r)
      S_ACC: begin
        bus.in_ready = 1'b1;
        if (close_s) begin
          next_state_s = S_OUT;
        end else begin
          next_state_s = S_ACC;
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          next_state_s = S_ACC;
        end else begin
          next_state_s = S_OUT;
        end
      end
      default: begin
        next_state_s = S_ACC;
      end
    endcase
  end

  // Accumulator, beat counter and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= '0;
      cnt_r  <= 5'd0;
      dout_r <= 8'h00;
      sat_r  <= 1'b0;
    end else if (close_s) begin
      acc_r  <= '0;
      cnt_r  <= 5'd0;
      dout_r <= sum_q_s;
      sat_r  <= sum_sat_s;
    end else if (accept_s) begin
      acc_r  <= sum_s;
      cnt_r  <= cnt_r + 5'd1;
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
    end
  end

  assign bus.dout = dout_r;
  assign bus.sat  = sat_r;

endmodule

// File: tb/tb_fx_acc_sat.sv
// tb_fx_acc_sat: directed and randomized checks of fx_acc_sat against an
// integer reference model of the frame sum and its Q4.4 clipping.
module tb_fx_acc_sat;

  localparam int LEN = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  // reference model state
  int         m_sum  = 0;
  int         m_cnt  = 0;
  logic       m_pend = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic       m_sat  = 1'b0;

  fx_acc_sat_if bus ();

  fx_acc_sat #(.LEN(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: plain integer sum, clipped only when the frame closes
  task automatic model_accept(input logic [7:0] d, input logic l);
    m_sum += int'($signed(d));
    m_cnt += 1;
    if (l || m_cnt == LEN) begin
      if (m_sum > 127) begin
        m_dout = 8'h7F; m_sat = 1'b1;
      end else if (m_sum < -128) begin
        m_dout = 8'h80; m_sat = 1'b1;
      end else begin
        m_dout = 8'(m_sum); m_sat = 1'b0;
      end
      m_pend = 1'b1;
      m_sum  = 0;
      m_cnt  = 0;
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_pend = 1'b0; m_dout = 8'h00; m_sat = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_dout", bus.dout, 8'h00);
    check("rst_sat", {7'd0, bus.sat}, 8'h00);
    check("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst_in_ready", {7'd0, bus.in_ready}, 8'h01);
  endtask

  // Send one beat; out_valid must follow the model exactly one edge later
  task automatic beat(input logic [7:0] d, input logic l);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_beat", {7'd0, bus.in_ready}, 8'h01);
    bus.din      = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    @(posedge clk); #1;
    model_accept(d, l);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("out_valid_after_beat", {7'd0, bus.out_valid}, {7'd0, m_pend});
    if (m_pend) begin
      check("in_ready_pending", {7'd0, bus.in_ready}, 8'h00);
      check("dout", bus.dout, m_dout);
      check("sat", {7'd0, bus.sat}, {7'd0, m_sat});
    end
  endtask

  task automatic take_result(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", {7'd0, bus.out_valid}, 8'h01);
      check("hold_dout", bus.dout, m_dout);
    end
    check("take_out_valid", {7'd0, bus.out_valid}, 8'h01);
    check("take_dout", bus.dout, m_dout);
    check("take_sat", {7'd0, bus.sat}, {7'd0, m_sat});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    m_pend = 1'b0;
    check("post_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("post_in_ready", {7'd0, bus.in_ready}, 8'h01);
  endtask

  initial begin
    bus.din = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // four beats of 1.0 -> 4.0
    for (int i = 0; i < 4; i++) beat(8'h10, i == 3);
    check("four_ones", bus.dout, 8'h40);
    take_result(0);

    // positive and negative clipping
    for (int i = 0; i < 3; i++) beat(8'h70, i == 2);
    check("pos_clip", bus.dout, 8'h7F);
    take_result(1);
    for (int i = 0; i < 2; i++) beat(8'h90, i == 1);
    check("neg_clip", bus.dout, 8'h80);
    take_result(0);

    // intermediate sum out of range must not clip
    beat(8'h70, 1'b0); beat(8'h70, 1'b0); beat(8'h90, 1'b0); beat(8'h90, 1'b1);
    check("wide_acc", bus.dout, 8'h00);
    check("wide_acc_sat", {7'd0, bus.sat}, 8'h00);
    take_result(0);

    // LEN beats with no in_last close on the LEN-th beat
    for (int i = 0; i < LEN; i++) beat(8'h01, 1'b0);
    check("len_close", bus.dout, 8'h10);
    check("len_blocks_17th", {7'd0, bus.in_ready}, 8'h00);
    take_result(0);

    // stall with in_valid high: nothing absorbed, result stable
    beat(8'h25, 1'b1);
    bus.din = 8'h33; bus.in_valid = 1'b1; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready", {7'd0, bus.in_ready}, 8'h00);
      check("stall_dout", bus.dout, 8'h25);
      check("stall_sat", {7'd0, bus.sat}, 8'h00);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    take_result(0);
    beat(8'hF8, 1'b1);
    check("no_absorb", bus.dout, 8'hF8);
    take_result(0);

    // reset mid-frame discards partial sum
    beat(8'h10, 1'b0); beat(8'h10, 1'b0);
    do_reset();
    beat(8'h08, 1'b1);
    check("after_rst_dout", bus.dout, 8'h08);
    check("after_rst_sat", {7'd0, bus.sat}, 8'h00);

    // reset in S_OUT drops the pending result
    do_reset();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int n;
      n = int'($urandom_range(1, 18));
      for (int i = 0; i < n && !m_pend; i++) begin
        beat(8'($urandom), (i == n - 1) && ($urandom_range(0, 3) != 0));
      end
      if (!m_pend) begin
        beat(8'($urandom), 1'b1);
      end
      take_result(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
